// File: rtl/lfsr_param.sv
// lfsr_param: parametrised Fibonacci/Galois LFSR with multi-step advance,
// zero-seed protection, saturating advance counter and period-wrap flag.
module lfsr_param #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003),
  parameter int unsigned      MODE  = 0,
  parameter int unsigned      STEPS = 1,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1),
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             ld_en,
  input  logic             shift_en,
  output logic [WIDTH-1:0] lfsr_out,
  output logic [STEPS-1:0] bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] shift_cnt
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_q;
  logic [STEPS-1:0] bits_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lockup_q;
  logic             wrap_q;

  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] adv_safe;
  logic [STEPS-1:0] adv_bits;
  logic [WIDTH-1:0] ld_val;
  logic             ld_zero;
  logic [CNT_W-1:0] cnt_nxt;

  // One LFSR step in the selected form; output bit is the old MSB.
  function automatic logic [WIDTH-1:0] step1(
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] r;
    if (MODE == 0) begin
      r = {s[WIDTH-2:0], ^(s & TAPS)};
    end else begin
      r = {s[WIDTH-2:0], 1'b0}
        ^ (s[WIDTH-1] ? TAPS : '0);
    end
    return r;
  endfunction

  // Unrolled STEPS-fold advance; first step lands in the MSB of bits.
  always_comb begin
    logic [WIDTH-1:0] s;
    s        = state_q;
    adv_bits = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      adv_bits[STEPS-1-k] = s[WIDTH-1];
      s = step1(s);
    end
    adv = s;
  end

  // Never let a degenerate tap mask park the register at zero.
  assign adv_safe = (adv == '0) ? INIT : adv;

  // Zero seeds are replaced so the register can never lock up.
  assign ld_zero = (seed == '0);
  assign ld_val  = ld_zero ? INIT : seed;

  // Advance counter sticks at all-ones instead of wrapping.
  assign cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // State update: reset beats load, load beats shift; flags are pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      seed_q   <= INIT;
      bits_q   <= '0;
      cnt_q    <= '0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else if (ld_en) begin
      state_q  <= ld_val;
      seed_q   <= ld_val;
      bits_q   <= '0;
      cnt_q    <= '0;
      lockup_q <= ld_zero;
      wrap_q   <= 1'b0;
    end else if (shift_en) begin
      state_q  <= adv_safe;
      bits_q   <= adv_bits;
      cnt_q    <= cnt_nxt;
      lockup_q <= 1'b0;
      wrap_q   <= (adv_safe == seed_q);
    end else begin
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end
  end

  assign lfsr_out  = state_q;
  assign bit_out   = bits_q;
  assign shift_cnt = cnt_q;
  assign lockup    = lockup_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_param.sv
// tb_lfsr_param: directed checks of lfsr_param across width,
// form, multi-step and counter-width configurations.
module tb_lfsr_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 32-bit default instance
  logic [31:0] seed_a = '0;
  logic        ld_a = 0, sh_a = 0;
  logic [31:0] out_a;
  logic [0:0]  bit_a;
  logic        lk_a, wr_a;
  logic [15:0] cnt_a;

  lfsr_param u_a (
    .clk(clk), .rst(rst), .seed(seed_a),
    .ld_en(ld_a), .shift_en(sh_a),
    .lfsr_out(out_a), .bit_out(bit_a),
    .lockup(lk_a), .wrap(wr_a), .shift_cnt(cnt_a)
  );

  // 4-bit Fibonacci
  logic [3:0]  seed_f = '0;
  logic        ld_f = 0, sh_f = 0;
  logic [3:0]  out_f;
  logic [0:0]  bit_f;
  logic        lk_f, wr_f;
  logic [15:0] cnt_f;

  lfsr_param #(
    .WIDTH(4), .TAPS(4'b1001), .MODE(0)
  ) u_f (
    .clk(clk), .rst(rst), .seed(seed_f),
    .ld_en(ld_f), .shift_en(sh_f),
    .lfsr_out(out_f), .bit_out(bit_f),
    .lockup(lk_f), .wrap(wr_f), .shift_cnt(cnt_f)
  );

  // 4-bit Galois
  logic [3:0]  seed_g = '0;
  logic        ld_g = 0, sh_g = 0;
  logic [3:0]  out_g;
  logic [0:0]  bit_g;
  logic        lk_g, wr_g;
  logic [15:0] cnt_g;

  lfsr_param #(
    .WIDTH(4), .TAPS(4'b0011), .MODE(1)
  ) u_g (
    .clk(clk), .rst(rst), .seed(seed_g),
    .ld_en(ld_g), .shift_en(sh_g),
    .lfsr_out(out_g), .bit_out(bit_g),
    .lockup(lk_g), .wrap(wr_g), .shift_cnt(cnt_g)
  );

  // 4-bit Galois, 3 steps per advance
  logic [3:0]  seed_m = '0;
  logic        ld_m = 0, sh_m = 0;
  logic [3:0]  out_m;
  logic [2:0]  bit_m;
  logic        lk_m, wr_m;
  logic [15:0] cnt_m;

  lfsr_param #(
    .WIDTH(4), .TAPS(4'b0011), .MODE(1), .STEPS(3)
  ) u_m (
    .clk(clk), .rst(rst), .seed(seed_m),
    .ld_en(ld_m), .shift_en(sh_m),
    .lfsr_out(out_m), .bit_out(bit_m),
    .lockup(lk_m), .wrap(wr_m), .shift_cnt(cnt_m)
  );

  // 4-bit Fibonacci with 4-bit counter
  logic [3:0]  seed_c = '0;
  logic        ld_c = 0, sh_c = 0;
  logic [3:0]  out_c;
  logic [0:0]  bit_c;
  logic        lk_c, wr_c;
  logic [3:0]  cnt_c;

  lfsr_param #(
    .WIDTH(4), .TAPS(4'b1001), .MODE(0), .CNT_W(4)
  ) u_c (
    .clk(clk), .rst(rst), .seed(seed_c),
    .ld_en(ld_c), .shift_en(sh_c),
    .lfsr_out(out_c), .bit_out(bit_c),
    .lockup(lk_c), .wrap(wr_c), .shift_cnt(cnt_c)
  );

  logic [3:0] exp_f [15] = '{
    4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
    4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1
  };

  logic [3:0] exp_g [15] = '{
    4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
    4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1
  };

  function automatic logic [3:0] gstep(input logic [3:0] s);
    return s[3] ? ({s[2:0], 1'b0} ^ 4'b0011)
                : {s[2:0], 1'b0};
  endfunction

  initial begin
    logic [3:0] prev;
    logic [3:0] ms;
    logic [2:0] mb;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out",  64'(out_a), 64'h1);
    chk("rst_bit",  64'(bit_a), 64'h0);
    chk("rst_cnt",  64'(cnt_a), 64'h0);
    chk("rst_lock", 64'(lk_a),  64'h0);
    chk("rst_wrap", 64'(wr_a),  64'h0);

    // 32-bit default load + single shift
    seed_a = 32'h0000_3039;
    ld_a   = 1'b1;
    tick();
    ld_a = 1'b0;
    chk("a_load", 64'(out_a), 64'h3039);
    chk("a_lcnt", 64'(cnt_a), 64'h0);
    sh_a = 1'b1;
    tick();
    sh_a = 1'b0;
    chk("a_shift", 64'(out_a), 64'h6073);
    chk("a_bit",   64'(bit_a), 64'h0);
    chk("a_cnt",   64'(cnt_a), 64'h1);

    // Fibonacci full period
    seed_f = 4'h1;
    ld_f   = 1'b1;
    tick();
    ld_f = 1'b0;
    sh_f = 1'b1;
    prev = 4'h1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("f_seq",  64'(out_f), 64'(exp_f[i]));
      chk("f_bit",  64'(bit_f), 64'(prev[3]));
      chk("f_wrap", 64'(wr_f),  64'(i == 14));
      prev = exp_f[i];
    end
    sh_f = 1'b0;
    chk("f_cnt", 64'(cnt_f), 64'd15);

    // Galois full period
    seed_g = 4'h1;
    ld_g   = 1'b1;
    tick();
    ld_g = 1'b0;
    sh_g = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("g_seq",  64'(out_g), 64'(exp_g[i]));
      chk("g_wrap", 64'(wr_g),  64'(i == 14));
    end
    sh_g = 1'b0;
    chk("g_cnt", 64'(cnt_g), 64'd15);

    // Galois, 3 steps per advance
    seed_m = 4'h1;
    ld_m   = 1'b1;
    tick();
    ld_m = 1'b0;
    sh_m = 1'b1;
    ms = 4'h1;
    for (int i = 0; i < 6; i++) begin
      tick();
      mb = '0;
      for (int k = 0; k < 3; k++) begin
        mb[2-k] = ms[3];
        ms = gstep(ms);
      end
      chk("m_seq",  64'(out_m), 64'(ms));
      chk("m_bits", 64'(bit_m), 64'(mb));
      chk("m_wrap", 64'(wr_m),  64'(ms == 4'h1));
      if (i == 0) begin
        chk("m_dir0", 64'(out_m), 64'h8);
        chk("m_dirb0", 64'(bit_m), 64'h0);
      end
      if (i == 1) begin
        chk("m_dir1", 64'(out_m), 64'hC);
        chk("m_dirb1", 64'(bit_m), 64'h4);
      end
    end
    sh_m = 1'b0;

    // Zero seed lockup, then load beating shift
    seed_f = 4'h0;
    ld_f   = 1'b1;
    tick();
    ld_f = 1'b0;
    chk("z_out",   64'(out_f), 64'h1);
    chk("z_lock",  64'(lk_f),  64'h1);
    tick();
    chk("z_lock1", 64'(lk_f),  64'h0);
    chk("z_hold",  64'(out_f), 64'h1);
    seed_f = 4'h5;
    ld_f   = 1'b1;
    sh_f   = 1'b1;
    tick();
    ld_f = 1'b0;
    sh_f = 1'b0;
    chk("ls_out",  64'(out_f), 64'h5);
    chk("ls_cnt",  64'(cnt_f), 64'h0);
    chk("ls_lock", 64'(lk_f),  64'h0);

    // Counter saturation from reset state
    sh_c = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("c_cnt", 64'(cnt_c),
          64'((i + 1 > 15) ? 15 : i + 1));
      chk("c_wrap", 64'(wr_c), 64'(i == 14));
    end
    chk("c_out", 64'(out_c), 64'h1 * 64'(exp_f[4]));

    // Reset beats shift_en
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    sh_c = 1'b0;
    chk("cr_out",  64'(out_c), 64'h1);
    chk("cr_bit",  64'(bit_c), 64'h0);
    chk("cr_cnt",  64'(cnt_c), 64'h0);
    chk("cr_lock", 64'(lk_c),  64'h0);
    chk("cr_wrap", 64'(wr_c),  64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
